// File: rtl/ast_mux.sv
// Avalon-ST packet mux: packet-atomic round-robin merge of RX_DIR sources onto one sink.
// Optional macro AST_MUX_CHANNEL_TAG_EN tags the granted source index into the low channel bits.
module ast_mux #(
   parameter int unsigned  DATA_WIDTH    = 64,
   parameter int unsigned  CHANNEL_WIDTH = 10,
   parameter int unsigned  RX_DIR        = 4,
   parameter int unsigned  DIR_SEL_WIDTH = $clog2(RX_DIR),
   localparam int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8)
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR-1:0],
   input  logic                     ast_startofpacket_i [RX_DIR-1:0],
   input  logic                     ast_endofpacket_i   [RX_DIR-1:0],
   input  logic                     ast_valid_i         [RX_DIR-1:0],
   input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR-1:0],
   input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR-1:0],
   output logic                     ast_ready_o         [RX_DIR-1:0],
   output logic [DATA_WIDTH-1:0]    ast_data_o,
   output logic                     ast_startofpacket_o,
   output logic                     ast_endofpacket_o,
   output logic                     ast_valid_o,
   output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
   output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
   input  logic                     ast_ready_i
);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e                   state_q, state_d;
   logic [DIR_SEL_WIDTH-1:0] grant_q, grant_d;
   logic [DIR_SEL_WIDTH-1:0] last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     sop_q, sop_d;
   logic                     eop_q, eop_d;
   logic                     valid_q, valid_d;
   logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
   logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
   logic [CHANNEL_WIDTH-1:0] chan_sel;
   logic                     out_free;
   logic                     accept;
   logic                     found;
   logic [DIR_SEL_WIDTH-1:0] idx;

   assign out_free = !valid_q || ast_ready_i;
   assign accept   = (state_q == StBusy) && ast_valid_i[grant_q] && out_free;

`ifdef AST_MUX_CHANNEL_TAG_EN
   if (CHANNEL_WIDTH <= DIR_SEL_WIDTH) begin : g_chan_width_check
      $error("ast_mux: CHANNEL_WIDTH must exceed DIR_SEL_WIDTH when tagging");
   end
   assign chan_sel = {ast_channel_i[grant_q][CHANNEL_WIDTH-1-DIR_SEL_WIDTH:0], grant_q};
`else
   assign chan_sel = ast_channel_i[grant_q];
`endif

   // Arbitration and packet tracking; search starts one past the last finished source.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      found        = 1'b0;
      idx          = '0;
      unique case (state_q)
         StIdle: begin
            for (int k = 1; k <= int'(RX_DIR); k++) begin
               idx = DIR_SEL_WIDTH'((int'(last_grant_q) + k) % int'(RX_DIR));
               if (!found && ast_valid_i[idx] && ast_startofpacket_i[idx]) begin
                  found   = 1'b1;
                  grant_d = idx;
               end
            end
            if (found) begin
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (accept && ast_endofpacket_i[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Idle drains orphan (non-SOP) beats; reset forces every ready low without a clock.
   always_comb begin
      for (int i = 0; i < int'(RX_DIR); i++) begin
         ast_ready_o[i] = 1'b0;
      end
      if (arst_n_i) begin
         if (state_q == StIdle) begin
            for (int i = 0; i < int'(RX_DIR); i++) begin
               ast_ready_o[i] = ast_valid_i[i] && !ast_startofpacket_i[i];
            end
         end else begin
            ast_ready_o[grant_q] = out_free;
         end
      end
   end

   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      empty_d   = empty_q;
      channel_d = channel_q;
      if (accept) begin
         valid_d   = 1'b1;
         data_d    = ast_data_i[grant_q];
         sop_d     = ast_startofpacket_i[grant_q];
         eop_d     = ast_endofpacket_i[grant_q];
         empty_d   = ast_empty_i[grant_q];
         channel_d = chan_sel;
      end else if (ast_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= DIR_SEL_WIDTH'(RX_DIR - 1);
         valid_q      <= 1'b0;
         data_q       <= '0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         empty_q      <= '0;
         channel_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         empty_q      <= empty_d;
         channel_q    <= channel_d;
      end
   end

   assign ast_data_o          = data_q;
   assign ast_startofpacket_o = sop_q;
   assign ast_endofpacket_o   = eop_q;
   assign ast_valid_o         = valid_q;
   assign ast_empty_o         = empty_q;
   assign ast_channel_o       = channel_q;

endmodule

// File: doc/ast_mux.md
# ast_mux

Avalon-ST packet multiplexer: merges RX_DIR independent Avalon-ST sources onto one Avalon-ST sink with packet-atomic round-robin arbitration. It is the converging counterpart of ast_dmx. A packet stream split by ast_dmx can be recombined by ast_mux, and a bench can loop one into the other. A single registered output stage keeps the sink path timing-clean.

## Interface
- DATA_WIDTH, 64: data bus width in bits, multiple of 8.
- CHANNEL_WIDTH, 10: channel field width.
- RX_DIR, 4: number of input sources, at least 2.
- DIR_SEL_WIDTH, $clog2(RX_DIR): width of the source index.
- EMPTY_WIDTH (localparam): $clog2(DATA_WIDTH/8).

Ports (all unpacked arrays are indexed [RX_DIR-1:0]):
- clk_i  in  1  single clock; all logic is rising-edge.
- arst_n_i  in  1  asynchronous, active-low reset.
- ast_data_i  in  DATA_WIDTH[RX_DIR]  per-source data.
- ast_startofpacket_i  in  1[RX_DIR]  per-source SOP.
- ast_endofpacket_i  in  1[RX_DIR]  per-source EOP.
- ast_valid_i  in  1[RX_DIR]  per-source valid.
- ast_empty_i  in  EMPTY_WIDTH[RX_DIR]  empty bytes; meaningful only with EOP.
- ast_channel_i  in  CHANNEL_WIDTH[RX_DIR]  per-source channel.
- ast_ready_o  out  1[RX_DIR]  per-source ready.
- ast_data_o  out  DATA_WIDTH  merged data.
- ast_startofpacket_o  out  1  merged SOP.
- ast_endofpacket_o  out  1  merged EOP.
- ast_valid_o  out  1  merged valid.
- ast_empty_o  out  EMPTY_WIDTH  merged empty.
- ast_channel_o  out  CHANNEL_WIDTH  merged channel (see Configuration).
- ast_ready_i  in  1  sink ready.

## Operation
- FSM has two states: IDLE and BUSY. Registers: grant (DIR_SEL_WIDTH bits) and last_grant.
- IDLE arbitration:
  - Candidates are sources with valid=1 and sop=1.
  - Search starts at (last_grant+1) mod RX_DIR and takes the first candidate in ascending, wrapping order.
  - When a candidate is found, load grant and go to BUSY.
  - If there is no candidate, stay in IDLE.
- BUSY transfer:
  - Only the granted source sees ast_ready_o = out_free.
  - out_free = !ast_valid_o || ast_ready_i.
  - A beat is accepted when ast_valid_i[grant] && out_free. The beat is copied into the output register at that edge.
  - Accepting a beat with eop=1: last_grant<=grant and go to IDLE. This covers single-beat packets with sop&eop.
  - A source with sop=1 mid-packet has that sop forwarded unchanged; the mux never repairs framing.
- Orphan drain: in IDLE, ast_ready_o[i]=1 for any source with valid=1 and sop=0. These beats are discarded and never forwarded.
- Output register:
  - Loads on every accepted beat.
  - ast_valid_o is cleared when ast_ready_i=1 and no new beat is accepted.
  - Payload holds while ast_valid_o=1 && ast_ready_i=0.
- Non-granted sources with valid SOP wait with ready=0. They must hold data stable (Avalon-ST rule).

## Timing
- Reset, asynchronous, applies immediately without waiting for a clock edge:
  - All outputs go to 0, including every ast_ready_o.
  - state=IDLE, grant=0, last_grant=RX_DIR-1, so source 0 wins first.
- Release is synchronous to the next clk_i edge.
- Arbitration latency: SOP valid in IDLE at cycle N → grant registered at edge N → ready high during N+1.
- First beat appears on the output at N+2. Throughput is then 1 beat/cycle while sink ready=1.
- Data latency: 1 cycle from acceptance to ast_valid_o.
- Packet boundary: after an EOP is accepted there is exactly one cycle in IDLE before the next grant. Two back-to-back packets cost one bubble.
- Full ready path: ast_ready_o[grant] follows ast_ready_i combinationally when ast_valid_o=1.
- Reset mid-packet: the partial packet is lost. The output shows no EOP, and the sources restart with a new SOP.

## Configuration
- AST_MUX_CHANNEL_TAG_EN defined:
  - ast_channel_o = {ast_channel_i[grant][CHANNEL_WIDTH-1-DIR_SEL_WIDTH:0], grant}. The source index is placed in the low bits.
  - Requires CHANNEL_WIDTH > DIR_SEL_WIDTH; elaboration fails otherwise.
- Undefined: ast_channel_o = ast_channel_i[grant] unchanged.

## Test plan
- Single source: src 2 sends a 5-beat packet with data 1..5 and empty=3 on the last beat; sink ready=1 → output beats 1..5, SOP on beat 1, EOP with empty=3 on beat 5, first valid 2 cycles after SOP presented.
- Round-robin: srcs 0, 1 and 3 all hold 3-beat packets from reset → output order 0, 1, 3, then 0 again. One bubble appears between packets. Source id is visible on channel[1:0] with AST_MUX_CHANNEL_TAG_EN.
- Backpressure: sink ready toggles 1,0,0,1 during a 4-beat packet → no beat is lost or duplicated, output payload stays stable while ready=0, and ast_ready_o[grant]=0 in those cycles.
- Orphan drain: src 1 asserts valid with sop=0 for 3 beats while idle → ast_ready_o[1]=1, ast_valid_o stays 0, and the next SOP packet passes intact.
- Single-beat packets: srcs 0 and 1 continuously send sop=eop=1 beats → they alternate 0,1,0,1 at one beat per 2 cycles.
- Reset mid-packet: assert arst_n_i=0 on beat 3 of 6 → all outputs read 0 within the same cycle. After release, src 0 is granted first again.
